instruction_fetch_unit: RTL and testbench
=========================================

// Module: instruction_fetch_unit
// PURPOSE
//  Front end of the Experimento4 soft CPU. Drives the instruction ROM
//  address, registers the returned 28-bit word and presents it to decode/execute.
//  Resolves NOP delays and JMP locally. Accepts branch redirects and
//  stalls from execute. Sits directly upstream of the ROM and feeds the decoder.
// PARAMETERS
//  ADDR_WIDTH   16       PC / ROM address width
//  INSTR_WIDTH  28       instruction word width; opcode = [27:24]
//  DELAY_WIDTH  24       NOP delay count field width = [23:0]
//  RESET_PC     16'd0    PC value after reset
// PORTS
//  Clock          in   1            system clock, rising edge
//  Reset          in   1            asynchronous, active-low reset
//  oInstrAddress  out  ADDR_WIDTH   ROM address (= PC)
//  iInstruction   in   INSTR_WIDTH  ROM data; combinational, valid in same cycle
//  oInstruction   out  INSTR_WIDTH  registered instruction to decode
//  oValid         out  1            oInstruction is a real instruction to execute
//  iStall         in   1            execute busy: hold PC, oInstruction, oValid
//  iBranchTaken   in   1            taken BLE/branch from execute: redirect
//  iBranchTarget  in   ADDR_WIDTH   redirect address
//  oDelayActive   out  1            NOP delay in progress
// BEHAVIOUR
//  - Reset (async, Reset==0):
//    - PC=RESET_PC, oInstruction=0, oValid=0, delay cnt=0.
//    - oDelayActive=0, state=RUN.
//  - Priority each edge: iBranchTaken > iStall > state action.
//  - Branch: PC<=iBranchTarget; oValid<=0; cnt<=0; state<=RUN.
//    - Aborts any delay and overrides iStall.
//  - Stall (no branch): all registers, including cnt, hold.
//  - RUN, word W=iInstruction at PC:
//    - opcode `NOP: oValid<=0; PC<=PC+1.
//      - N=W[23:0]: if N!=0, cnt<=N and state<=DELAY.
//      - If N==0: single bubble, stay in RUN.
//    - opcode `JMP: PC<=W[15:0]; oValid<=0. JMP is never forwarded.
//    - Any other opcode: oInstruction<=W; oValid<=1; PC<=PC+1.
//  - DELAY:
//    - oValid=0 and oDelayActive=1. PC and oInstruction hold.
//    - cnt<=cnt-1 each cycle.
//    - When cnt==1, state<=RUN.
//    - Total bubbles for NOP N = N+1 cycles.
//  - Arithmetic: PC+1 wraps modulo 2^ADDR_WIDTH (16'hFFFF -> 16'h0000).
//  - Latency: a non-NOP/JMP word at PC appears on oInstruction with oValid
//    1 clock after PC is presented.
//  - iBranchTaken in the same cycle a JMP or NOP is fetched: branch wins.
//  - oInstrAddress = PC, driven combinationally from the PC register.
// STRUCTURE
//  - Opcode codes (`NOP, `JMP, ...) and field positions come from the
//    shared Defintions.v header. No local opcode constants.
//  - One sub-module: fetch_delay_counter.
//    - DELAY_WIDTH down-counter with load, enable, clear.
//    - Output done = (cnt==1).
//  - PC register and the RUN/DELAY FSM live in the top module.
// TESTING
//  1. Reset mid-DELAY (cnt=2000):
//     - Response: next cycle oInstrAddress=0, oValid=0, oDelayActive=0.
//  2. ROM 0:ADD, 1:STO, 2:VGA, no stall:
//     - Response: oValid=1 for 3 consecutive cycles.
//     - oInstruction sequence is ROM[0], ROM[1], ROM[2].
//  3. ROM 0:{`NOP,24'd3}, 1:ADD:
//     - Response: oValid=0 for 4 cycles.
//     - oDelayActive=1 for exactly 3 cycles.
//     - ADD appears on oInstruction on the 5th edge.
//  4. ROM 5:{`JMP,8'd0,16'd0}:
//     - Response: oValid=0 one cycle; next oInstrAddress=0.
//     - The JMP word is never seen on oInstruction with oValid=1.
//  5. iStall=1 for 3 cycles while oInstruction=ADD at PC=9:
//     - Response: PC=9 and oInstruction held.
//     - oValid stays 1 and no duplicate advance occurs.
//  6. iBranchTaken=1, iBranchTarget=6, asserted together with iStall=1
//     during DELAY:
//     - Response: next oInstrAddress=6, oValid=0, oDelayActive=0.
//  7. PC=16'hFFFF with an ADD fetched:
//     - Response: next oInstrAddress=16'h0000.

Source files
------------

// File: rtl/instruction_fetch_unit_pkg.sv
// Shared Experimento4 instruction definitions: opcode codes, field positions
// and the fetch FSM state type.
package instruction_fetch_unit_pkg;

    typedef enum logic [3:0] {
        OP_NOP  = 4'h0,
        OP_LED  = 4'h1,
        OP_BLE  = 4'h2,
        OP_STO  = 4'h3,
        OP_ADD  = 4'h4,
        OP_JMP  = 4'h5,
        OP_SUB  = 4'h6,
        OP_SMUL = 4'h7,
        OP_VGA  = 4'h8
    } opcode_e;

    localparam int OPCODE_MSB     = 27;
    localparam int OPCODE_LSB     = 24;
    localparam int DELAY_MSB      = 23;
    localparam int DELAY_LSB      = 0;
    localparam int JMP_TARGET_MSB = 15;
    localparam int JMP_TARGET_LSB = 0;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_DELAY = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/instruction_fetch_unit_delay_counter.sv
// NOP delay down-counter: clear beats load beats enable; done flags the last
// delay cycle so the FSM can leave DELAY on the same edge the count expires.
module fetch_delay_counter #(
    parameter int DELAY_WIDTH = 24
) (
    input  logic                   Clock,
    input  logic                   Reset,
    input  logic                   clear,
    input  logic                   load,
    input  logic                   enable,
    input  logic [DELAY_WIDTH-1:0] load_value,
    output logic                   done
);

    localparam logic [DELAY_WIDTH-1:0] CNT_ONE = {{(DELAY_WIDTH-1){1'b0}}, 1'b1};

    logic [DELAY_WIDTH-1:0] cnt_q;
    logic [DELAY_WIDTH-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (load) begin
            cnt_d = load_value;
        end else if (enable && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_ONE;
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done = (cnt_q == CNT_ONE);

endmodule

// File: rtl/instruction_fetch_unit.sv
// Experimento4 fetch front end: drives the ROM address, registers the word
// for decode, and resolves NOP delays and JMP without involving execute.
//
// state    | meaning
// ST_RUN   | fetching: word at PC is decoded/forwarded every unstalled cycle
// ST_DELAY | NOP delay in progress: bubbles issued, PC and instruction held
module instruction_fetch_unit
    import instruction_fetch_unit_pkg::*;
#(
    parameter int                    ADDR_WIDTH  = 16,
    parameter int                    INSTR_WIDTH = 28,
    parameter int                    DELAY_WIDTH = 24,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0
) (
    input  logic                   Clock,
    input  logic                   Reset,
    output logic [ADDR_WIDTH-1:0]  oInstrAddress,
    input  logic [INSTR_WIDTH-1:0] iInstruction,
    output logic [INSTR_WIDTH-1:0] oInstruction,
    output logic                   oValid,
    input  logic                   iStall,
    input  logic                   iBranchTaken,
    input  logic [ADDR_WIDTH-1:0]  iBranchTarget,
    output logic                   oDelayActive
);

    localparam logic [ADDR_WIDTH-1:0] PC_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    fetch_state_e           state_q, state_d;
    logic [ADDR_WIDTH-1:0]  pc_q, pc_d;
    logic [INSTR_WIDTH-1:0] instr_q, instr_d;
    logic                   valid_q, valid_d;

    logic                   cnt_clear;
    logic                   cnt_load;
    logic                   cnt_enable;
    logic                   cnt_done;

    logic [3:0]             opcode;
    logic [DELAY_WIDTH-1:0] delay_field;
    logic [ADDR_WIDTH-1:0]  jmp_target;

    assign opcode      = iInstruction[OPCODE_MSB:OPCODE_LSB];
    assign delay_field = iInstruction[DELAY_MSB:DELAY_LSB];
    assign jmp_target  = iInstruction[JMP_TARGET_MSB:JMP_TARGET_LSB];

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        valid_d    = valid_q;
        cnt_clear  = 1'b0;
        cnt_load   = 1'b0;
        cnt_enable = 1'b0;

        if (iBranchTaken) begin
            pc_d      = iBranchTarget;
            valid_d   = 1'b0;
            cnt_clear = 1'b1;
            state_d   = ST_RUN;
        end else if (!iStall) begin
            case (state_q)
                ST_RUN: begin
                    if (opcode == OP_NOP) begin
                        valid_d = 1'b0;
                        pc_d    = pc_q + PC_ONE;
                        // A zero count is a single bubble; DELAY is never entered.
                        if (delay_field != '0) begin
                            cnt_load = 1'b1;
                            state_d  = ST_DELAY;
                        end
                    end else if (opcode == OP_JMP) begin
                        pc_d    = jmp_target;
                        valid_d = 1'b0;
                    end else begin
                        instr_d = iInstruction;
                        valid_d = 1'b1;
                        pc_d    = pc_q + PC_ONE;
                    end
                end
                ST_DELAY: begin
                    valid_d    = 1'b0;
                    cnt_enable = 1'b1;
                    if (cnt_done) begin
                        state_d = ST_RUN;
                    end
                end
                default: begin
                    state_d = ST_RUN;
                end
            endcase
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q <= ST_RUN;
            pc_q    <= RESET_PC;
            instr_q <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
        end
    end

    fetch_delay_counter #(
        .DELAY_WIDTH (DELAY_WIDTH)
    ) u_delay_counter (
        .Clock      (Clock),
        .Reset      (Reset),
        .clear      (cnt_clear),
        .load       (cnt_load),
        .enable     (cnt_enable),
        .load_value (delay_field),
        .done       (cnt_done)
    );

    assign oInstrAddress = pc_q;
    assign oInstruction  = instr_q;
    assign oValid        = valid_q;
    assign oDelayActive  = (state_q == ST_DELAY);

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: directed scenarios plus randomized ROM
// contents and stall/branch traffic, all checked against a bubble-count model.
module tb_instruction_fetch_unit;
    import instruction_fetch_unit_pkg::*;

    logic        Clock;
    logic        Reset;
    logic [15:0] oInstrAddress;
    logic [27:0] iInstruction;
    logic [27:0] oInstruction;
    logic        oValid;
    logic        iStall;
    logic        iBranchTaken;
    logic [15:0] iBranchTarget;
    logic        oDelayActive;

    logic [27:0] rom [0:65535];

    int checks_cnt;
    int errors_cnt;

    // reference model state
    logic [15:0] m_pc;
    logic [27:0] m_instr;
    logic        m_valid;
    int          m_bubbles_left;

    instruction_fetch_unit dut (
        .Clock         (Clock),
        .Reset         (Reset),
        .oInstrAddress (oInstrAddress),
        .iInstruction  (iInstruction),
        .oInstruction  (oInstruction),
        .oValid        (oValid),
        .iStall        (iStall),
        .iBranchTaken  (iBranchTaken),
        .iBranchTarget (iBranchTarget),
        .oDelayActive  (oDelayActive)
    );

    assign iInstruction = rom[oInstrAddress];

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_cnt++;
        if (obs !== exp) begin
            errors_cnt++;
            $display("FAIL %s observed=%0h expected=%0h at t=%0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [27:0] mk(input opcode_e op, input logic [23:0] f);
        return {op, f};
    endfunction

    task automatic model_reset();
        m_pc           = 16'h0000;
        m_instr        = '0;
        m_valid        = 1'b0;
        m_bubbles_left = 0;
    endtask

    task automatic model_edge(input logic st, input logic br, input logic [15:0] tgt);
        logic [27:0] w;
        if (br) begin
            m_pc           = tgt;
            m_valid        = 1'b0;
            m_bubbles_left = 0;
        end else if (!st) begin
            if (m_bubbles_left > 0) begin
                m_bubbles_left--;
                m_valid = 1'b0;
            end else begin
                w = rom[m_pc];
                if (w[27:24] == OP_NOP) begin
                    m_valid        = 1'b0;
                    m_pc           = m_pc + 16'd1;
                    m_bubbles_left = int'(w[23:0]);
                end else if (w[27:24] == OP_JMP) begin
                    m_pc    = w[15:0];
                    m_valid = 1'b0;
                end else begin
                    m_instr = w;
                    m_valid = 1'b1;
                    m_pc    = m_pc + 16'd1;
                end
            end
        end
    endtask

    task automatic compare_model(input string tag);
        chk({tag, ".addr"},  {16'h0, oInstrAddress}, {16'h0, m_pc});
        chk({tag, ".valid"}, {31'h0, oValid},        {31'h0, m_valid});
        chk({tag, ".dly"},   {31'h0, oDelayActive},  {31'h0, (m_bubbles_left > 0)});
        chk({tag, ".instr"}, {4'h0, oInstruction},   {4'h0, m_instr});
    endtask

    // Called at a negedge: drive inputs, take one rising edge, check at the next negedge.
    task automatic cycle(input string tag, input logic st, input logic br, input logic [15:0] tgt);
        iStall        = st;
        iBranchTaken  = br;
        iBranchTarget = tgt;
        @(posedge Clock);
        model_edge(st, br, tgt);
        @(negedge Clock);
        compare_model(tag);
    endtask

    task automatic do_reset();
        Reset = 1'b0;
        model_reset();
        #1;
        compare_model("rst");
        @(negedge Clock);
        Reset = 1'b1;
    endtask

    int n_dly;
    int n_bub;

    initial begin
        checks_cnt    = 0;
        errors_cnt    = 0;
        Reset         = 1'b0;
        iStall        = 1'b0;
        iBranchTaken  = 1'b0;
        iBranchTarget = '0;
        for (int i = 0; i < 65536; i++) rom[i] = mk(OP_ADD, 24'(i));
        model_reset();
        @(negedge Clock);

        // 1: reset while a long delay is counting
        rom[0] = mk(OP_NOP, 24'd2000);
        do_reset();
        for (int i = 0; i < 5; i++) cycle("t1_run", 1'b0, 1'b0, 16'h0);
        chk("t1_in_delay", {31'h0, oDelayActive}, 32'd1);
        Reset = 1'b0;
        model_reset();
        #1;
        chk("t1_rst_addr",  {16'h0, oInstrAddress}, 32'd0);
        chk("t1_rst_valid", {31'h0, oValid},        32'd0);
        chk("t1_rst_dly",   {31'h0, oDelayActive},  32'd0);
        @(negedge Clock);
        Reset = 1'b1;
        compare_model("t1_post");

        // 2: three straight-line instructions
        rom[0] = mk(OP_ADD, 24'h000111);
        rom[1] = mk(OP_STO, 24'h000222);
        rom[2] = mk(OP_VGA, 24'h000333);
        do_reset();
        cycle("t2_0", 1'b0, 1'b0, 16'h0);
        chk("t2_i0", {4'h0, oInstruction}, 32'h4000111);
        chk("t2_v0", {31'h0, oValid}, 32'd1);
        cycle("t2_1", 1'b0, 1'b0, 16'h0);
        chk("t2_i1", {4'h0, oInstruction}, 32'h3000222);
        chk("t2_v1", {31'h0, oValid}, 32'd1);
        cycle("t2_2", 1'b0, 1'b0, 16'h0);
        chk("t2_i2", {4'h0, oInstruction}, 32'h8000333);
        chk("t2_v2", {31'h0, oValid}, 32'd1);

        // 3: NOP 3 gives four bubbles, three of them flagged as delay
        rom[0] = mk(OP_NOP, 24'd3);
        rom[1] = mk(OP_ADD, 24'h0000AA);
        do_reset();
        n_dly = 0;
        n_bub = 0;
        for (int i = 0; i < 4; i++) begin
            cycle("t3_bub", 1'b0, 1'b0, 16'h0);
            if (!oValid) n_bub++;
            if (oDelayActive) n_dly++;
        end
        cycle("t3_add", 1'b0, 1'b0, 16'h0);
        chk("t3_bubbles",   n_bub, 32'd4);
        chk("t3_dly_count", n_dly, 32'd3);
        chk("t3_add_valid", {31'h0, oValid}, 32'd1);
        chk("t3_add_instr", {4'h0, oInstruction}, 32'h40000AA);

        // 4: JMP at 5 to 0 is consumed, never forwarded
        rom[5] = mk(OP_JMP, 24'h000000);
        cycle("t4_br", 1'b0, 1'b1, 16'd5);
        cycle("t4_jmp", 1'b0, 1'b0, 16'h0);
        chk("t4_valid", {31'h0, oValid}, 32'd0);
        chk("t4_addr",  {16'h0, oInstrAddress}, 32'd0);
        chk("t4_not_jmp", {31'h0, (oValid && oInstruction[27:24] == OP_JMP)}, 32'd0);

        // 5: stall holds ADD at PC=9
        rom[8] = mk(OP_ADD, 24'h000888);
        rom[9] = mk(OP_STO, 24'h000999);
        cycle("t5_br", 1'b0, 1'b1, 16'd8);
        cycle("t5_add", 1'b0, 1'b0, 16'h0);
        for (int i = 0; i < 3; i++) begin
            cycle("t5_stall", 1'b1, 1'b0, 16'h0);
            chk("t5_pc", {16'h0, oInstrAddress}, 32'd9);
            chk("t5_hold", {4'h0, oInstruction}, 32'h4000888);
            chk("t5_valid", {31'h0, oValid}, 32'd1);
        end
        cycle("t5_go", 1'b0, 1'b0, 16'h0);
        chk("t5_next", {4'h0, oInstruction}, 32'h3000999);
        chk("t5_pc10", {16'h0, oInstrAddress}, 32'd10);

        // 6: branch with stall during DELAY
        rom[16'h20] = mk(OP_NOP, 24'd10);
        cycle("t6_br", 1'b0, 1'b1, 16'h20);
        cycle("t6_nop", 1'b0, 1'b0, 16'h0);
        cycle("t6_dly", 1'b0, 1'b0, 16'h0);
        chk("t6_in_delay", {31'h0, oDelayActive}, 32'd1);
        cycle("t6_redir", 1'b1, 1'b1, 16'd6);
        chk("t6_addr",  {16'h0, oInstrAddress}, 32'd6);
        chk("t6_valid", {31'h0, oValid}, 32'd0);
        chk("t6_dly",   {31'h0, oDelayActive}, 32'd0);

        // 7: PC wrap
        rom[16'hFFFF] = mk(OP_ADD, 24'h00FFFF);
        cycle("t7_br", 1'b0, 1'b1, 16'hFFFF);
        cycle("t7_wrap", 1'b0, 1'b0, 16'h0);
        chk("t7_addr", {16'h0, oInstrAddress}, 32'd0);
        chk("t7_valid", {31'h0, oValid}, 32'd1);

        // randomized program in 0..255 plus the top word
        for (int i = 0; i < 256; i++) begin
            int r;
            r = int'($urandom_range(0, 9));
            if (r < 2)      rom[i] = mk(OP_NOP, 24'($urandom_range(0, 4)));
            else if (r < 3) rom[i] = mk(OP_JMP, {8'h00, 16'($urandom_range(0, 255))});
            else            rom[i] = {4'($urandom_range(1, 8)), 24'($urandom)};
            if (rom[i][27:24] == OP_JMP && r >= 3) rom[i][27:24] = OP_ADD;
        end
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            logic st, br;
            logic [15:0] tgt;
            st  = ($urandom_range(0, 3) == 0);
            br  = ($urandom_range(0, 11) == 0);
            tgt = ($urandom_range(0, 15) == 0) ? 16'hFFFF : 16'($urandom_range(0, 255));
            cycle("rnd", st, br, tgt);
        end

        $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
        $finish;
    end

endmodule
